tlc_input_conditioner: RTL

Front-end stage directly upstream of MustangTLC. It takes the raw, asynchronous brake pedal and turn-stalk switch contacts, synchronizes and debounces them, and resolves illegal stalk combinations. Its registered outputs drive MustangTLC's brake, turn_right and turn_left inputs. It also reports a sticky stalk fault when both turn contacts stay closed for too long.

---
 rtl/tlc_input_conditioner_pkg.sv | 23 ++
 rtl/tlc_switch_debouncer.sv | 48 ++++
 rtl/tlc_input_conditioner.sv | 89 ++++++++
 3 files changed

// File: rtl/tlc_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tlc_input_conditioner_pkg
// Brief   : Shared defaults and switch indexing for the MustangTLC front end.
// Revision: 1.0
// ============================================================================
package tlc_input_conditioner_pkg;

    localparam int C_DEBOUNCE_CYCLES = 4;
    localparam int C_CNT_W           = 8;
    localparam int C_FAULT_CYCLES    = 8;
    localparam int C_FLT_W           = 8;

    // Bit positions of each switch inside the packed switch vector.
    localparam int C_IDX_LEFT  = 0;
    localparam int C_IDX_RIGHT = 1;
    localparam int C_IDX_BRAKE = 2;
    localparam int C_NUM_SW    = 3;

    typedef logic [C_NUM_SW-1:0] sw_vec_t;

endpackage
`default_nettype wire

// File: rtl/tlc_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tlc_switch_debouncer
// Brief   : 2-flop synchronizer plus counter debouncer for one switch contact.
// Revision: 1.0
// ============================================================================
module tlc_switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            // Any sample agreeing with the accepted level restarts the count.
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_db;

endmodule
`default_nettype wire

// File: rtl/tlc_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tlc_input_conditioner
// Brief   : Debounces brake/stalk contacts, suppresses stalk conflicts and
//           latches a sticky fault when both stalks stay closed too long.
// Revision: 1.0
// ============================================================================
module tlc_input_conditioner
    import tlc_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter int CNT_W           = C_CNT_W,
    parameter int FAULT_CYCLES    = C_FAULT_CYCLES,
    parameter int FLT_W           = C_FLT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic brake_raw,
    input  logic turn_right_raw,
    input  logic turn_left_raw,
    output logic brake,
    output logic turn_right,
    output logic turn_left,
    output logic stalk_fault
);

    localparam logic [FLT_W-1:0] C_FAULT_MAX  = FLT_W'(FAULT_CYCLES);
    localparam logic [FLT_W-1:0] C_FAULT_LAST = FLT_W'(FAULT_CYCLES - 1);

    sw_vec_t w_raw;
    sw_vec_t w_db;
    logic    w_conflict;

    logic             r_brake;
    logic             r_right;
    logic             r_left;
    logic             r_fault;
    logic [FLT_W-1:0] r_fc;

    assign w_raw[C_IDX_BRAKE] = brake_raw;
    assign w_raw[C_IDX_RIGHT] = turn_right_raw;
    assign w_raw[C_IDX_LEFT]  = turn_left_raw;

    for (genvar gi = 0; gi < C_NUM_SW; gi++) begin : g_debounce
        tlc_switch_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debouncer (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (w_raw[gi]),
            .level (w_db[gi])
        );
    end

    assign w_conflict = w_db[C_IDX_RIGHT] & w_db[C_IDX_LEFT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brake <= 1'b0;
            r_right <= 1'b0;
            r_left  <= 1'b0;
            r_fault <= 1'b0;
            r_fc    <= '0;
        end else begin
            r_brake <= w_db[C_IDX_BRAKE];
            // Both stalks closed is never forwarded; the downstream FSM sees no turn.
            r_right <= w_db[C_IDX_RIGHT] & ~w_conflict;
            r_left  <= w_db[C_IDX_LEFT]  & ~w_conflict;
            if (w_conflict) begin
                if (r_fc != C_FAULT_MAX) begin
                    r_fc <= r_fc + 1'b1;
                end
                if (r_fc >= C_FAULT_LAST) begin
                    r_fault <= 1'b1;
                end
            end else begin
                r_fc <= '0;
            end
        end
    end

    assign brake       = r_brake;
    assign turn_right  = r_right;
    assign turn_left   = r_left;
    assign stalk_fault = r_fault;

endmodule
`default_nettype wire
